dest_reg_scoreboard: RTL and testbench

DEST_REG_SCOREBOARD -- requirements
Module: dest_reg_scoreboard

---
 rtl/dest_reg_scoreboard_pkg.sv | 11 +
 rtl/dest_reg_scoreboard_sb_stage.sv | 20 ++
 rtl/dest_reg_scoreboard.sv | 81 ++++++++
 tb/tb_dest_reg_scoreboard.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dest_reg_scoreboard_pkg.sv
// Shared processor constants and the scoreboard stage record.
package dest_reg_scoreboard_pkg;
    localparam int SB_DEPTH = 3;
    localparam int REG_W    = 5;
    localparam int CNT_W    = 16;

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
    } sb_entry_t;
endpackage

// File: rtl/dest_reg_scoreboard_sb_stage.sv
// One in-flight write slot: {valid, reg} with async and sync clear.
module sb_stage
    import dest_reg_scoreboard_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clr_i,
    input  sb_entry_t d_i,
    output sb_entry_t q_o
);
    sb_entry_t ent_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    ent_q <= '0;
        else if (clr_i) ent_q <= '0;
        else            ent_q <= d_i;
    end

    assign q_o = ent_q;
endmodule

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: tracks in-flight writes and stalls
// issue of any instruction that reads a still-pending register.
module dest_reg_scoreboard
    import dest_reg_scoreboard_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             IssueValid,
    input  logic             RegWrite,
    input  logic [REG_W-1:0] DestReg,
    input  logic [REG_W-1:0] RsAddr,
    input  logic [REG_W-1:0] RtAddr,
    input  logic             UseRs,
    input  logic             UseRt,
    input  logic             Flush,
    output logic             Stall,
    output logic [31:0]      PendingMask,
    output logic [CNT_W-1:0] StallCount
);
    sb_entry_t        stage_q [DEPTH];
    sb_entry_t        stage_d [DEPTH];
    logic [31:0]      mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard, wr_accept;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i].vld) begin
                if (UseRs && RsAddr != '0 && stage_q[i].rd == RsAddr) hazard = 1'b1;
                if (UseRt && RtAddr != '0 && stage_q[i].rd == RtAddr) hazard = 1'b1;
            end
        end
    end

    assign Stall     = IssueValid && hazard;
    assign wr_accept = IssueValid && !Stall && RegWrite && DestReg != '0;

    always_comb begin
        stage_d[0].vld = wr_accept;
        stage_d[0].rd  = wr_accept ? DestReg : '0;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    // Mask is built from next-state contents so it lines up with the stages.
    always_comb begin
        mask_d = '0;
        if (!Flush) begin
            for (int i = 0; i < DEPTH; i++)
                if (stage_d[i].vld) mask_d[stage_d[i].rd] = 1'b1;
        end
        mask_d[0] = 1'b0;
    end

    assign cnt_d = (Stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        sb_stage u_stage (
            .clk_i  (Clk),
            .rst_ni (Rst),
            .clr_i  (Flush),
            .d_i    (stage_d[g]),
            .q_o    (stage_q[g])
        );
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mask_q <= '0;
            cnt_q  <= '0;
        end else begin
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
        end
    end

    assign PendingMask = mask_q;
    assign StallCount  = cnt_q;
endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Randomized + directed bench for dest_reg_scoreboard against a
// list-of-pending-writes model.
module tb_dest_reg_scoreboard;
    localparam int DEPTH = 3;

    logic        Clk = 1'b0, Rst = 1'b0;
    logic        IssueValid = 1'b0, RegWrite = 1'b0, UseRs = 1'b0, UseRt = 1'b0, Flush = 1'b0;
    logic [4:0]  DestReg = '0, RsAddr = '0, RtAddr = '0;
    logic        Stall;
    logic [31:0] PendingMask;
    logic [15:0] StallCount;

    int total = 0, bad = 0;

    dest_reg_scoreboard #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .IssueValid(IssueValid), .RegWrite(RegWrite),
        .DestReg(DestReg), .RsAddr(RsAddr), .RtAddr(RtAddr), .UseRs(UseRs),
        .UseRt(UseRt), .Flush(Flush), .Stall(Stall), .PendingMask(PendingMask),
        .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    // Model: a list of accepted writes, each with the number of edges it has left.
    typedef struct {int r; int life;} wr_t;
    wr_t  inflight[$];
    wr_t  nxt[$];
    int   m_cnt = 0;
    logic m_st;

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        foreach (inflight[i]) m[inflight[i].r] = 1'b1;
        return m;
    endfunction

    function automatic logic m_stall();
        logic [31:0] m = m_mask();
        return IssueValid && ((UseRs && RsAddr != 0 && m[RsAddr]) ||
                              (UseRt && RtAddr != 0 && m[RtAddr]));
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            inflight.delete();
            m_cnt = 0;
        end else begin
            m_st = m_stall();
            if (m_st && m_cnt < 65535) m_cnt++;
            nxt.delete();
            foreach (inflight[i])
                if (inflight[i].life > 1) nxt.push_back('{inflight[i].r, inflight[i].life - 1});
            if (!m_st && IssueValid && RegWrite && DestReg != 0)
                nxt.push_back('{int'(DestReg), DEPTH});
            if (Flush) nxt.delete();
            inflight = nxt;
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            check("m_stall", 32'(Stall), 32'(m_stall()));
            check("m_mask", PendingMask, m_mask());
            check("m_cnt", 32'(StallCount), 32'(m_cnt));
        end
    end

    task automatic drv(logic iv, logic rw, logic [4:0] d, logic [4:0] rs, logic [4:0] rt,
                       logic urs, logic urt, logic fl);
        IssueValid = iv; RegWrite = rw; DestReg = d; RsAddr = rs; RtAddr = rt;
        UseRs = urs; UseRt = urt; Flush = fl;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] t4_mask [3];

    initial begin
        t4_mask[0] = 32'h18; t4_mask[1] = 32'h18; t4_mask[2] = 32'h10;
        drv(1, 1, 5, 5, 5, 1, 1, 0);
        #3;
        check("rst_stall", 32'(Stall), 0);
        check("rst_mask", PendingMask, 0);
        check("rst_cnt", 32'(StallCount), 0);
        @(posedge Clk); #1 Rst = 1'b1;

        // Producer then dependent read: DEPTH stall cycles.
        drv(1, 1, 5, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 5, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 check("t1_stall", 32'(Stall), 1);
            if (k == 0) check("t1_mask", PendingMask, 32'h20);
            step();
        end
        #1;
        check("t1_go", 32'(Stall), 0);
        check("t1_mask_end", PendingMask, 0);
        check("t1_cnt", 32'(StallCount), 3);
        step(); drv(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Register 0 is never pending.
        drv(1, 1, 0, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 1, 1, 0);
        #1 check("t2_stall", 32'(Stall), 0);
        check("t2_mask", PendingMask, 0);
        step();

        // Flush while a dependent read waits.
        drv(1, 1, 7, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 7, 0, 1, 1);
        #1 check("t3_stall", 32'(Stall), 1);
        step();
        drv(1, 0, 0, 0, 7, 0, 1, 0);
        #1 check("t3_after", 32'(Stall), 0);
        check("t3_mask", PendingMask, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 0, 0); step();

        // Unused Rs must not stall; Rt=4 stalls 3 cycles.
        drv(1, 1, 3, 0, 0, 0, 0, 0); step();
        drv(1, 1, 4, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 3, 4, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_stall", 32'(Stall), 1);
            check("t4_mask", PendingMask, t4_mask[k]);
            step();
        end
        #1 check("t4_go", 32'(Stall), 0);
        check("t4_mask_end", PendingMask, 0);
        step(); drv(0, 0, 0, 0, 0, 0, 0, 0); step();

        repeat (2000) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0);
            step();
        end

        // Asynchronous reset in the middle of a stall.
        drv(1, 0, 0, 0, 0, 0, 0, 1); step();
        drv(1, 1, 9, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 9, 0, 1, 0, 0);
        #1 check("t5_pre", 32'(Stall), 1);
        step();
        #1 Rst = 1'b0;
        #1;
        check("t5_stall", 32'(Stall), 0);
        check("t5_mask", PendingMask, 0);
        check("t5_cnt", 32'(StallCount), 0);
        step();
        Rst = 1'b1;

        // Self-dependent write keeps stalling 3 of every 4 cycles until saturation.
        drv(1, 1, 11, 11, 0, 1, 0, 0);
        repeat (87400) step();
        #1 check("t6_sat", 32'(StallCount), 32'hFFFF);
        repeat (8) step();
        #1 check("t6_hold", 32'(StallCount), 32'hFFFF);

        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
